// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input registered mux.
// Mode encodings and flattened-bus channel extraction.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  localparam int MAX_W  = 256;
  localparam int MAX_IN = 16;
  localparam int FLAT_W = MAX_W * MAX_IN;

  // Caller truncates the result to its own channel width.
  function automatic logic [MAX_W-1:0] chan_slice(
    input logic [FLAT_W-1:0] flat,
    input int                idx,
    input int                width
  );
    chan_slice = MAX_W'(flat >> (idx * width));
  endfunction

endpackage

// File: rtl/mux_n_pipe_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins.
// The pointer moves past the winner only on an accepted transfer.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;

  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_IN;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      if (int'(grant) + 1 == NUM_IN) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-input registered mux with valid/ready on every port.
// Explicit select or round-robin grant feeds a one-entry output register.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src
);

  logic              load_en;
  logic              take;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant;
  logic [FLAT_W-1:0] flat;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;

  assign flat    = FLAT_W'(in_data);
  assign load_en = ~out_valid_q | out_ready;
  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign take    = rst_n & grant_valid & load_en;

  if (MODE == MODE_RR) begin : g_rr
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
    ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (in_valid),
      .advance     (take),
      .grant       (grant),
      .grant_valid (grant_valid)
    );
  end else begin : g_sel
    always_comb begin
      grant       = sel;
      grant_valid = 1'b0;
      if (int'(sel) < NUM_IN) begin
        grant_valid = in_valid[sel];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = WIDTH'(chan_slice(flat, int'(grant), WIDTH));
      out_src_d   = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three instances checked against a
// transaction-level model, plus directed literal expectations.
module tb_mux_n_pipe;

  localparam int MD[3] = '{0, 0, 1};
  localparam int NI[3] = '{4, 3, 4};

  logic        clk;
  logic        rst_n;
  logic [3:0]  iv    [3];
  logic [31:0] idat  [3];
  logic [1:0]  sel   [3];
  logic        ordy  [3];
  logic        ov    [3];
  logic [7:0]  od    [3];
  logic [1:0]  os    [3];
  logic [3:0]  irdy0;
  logic [2:0]  irdy1;
  logic [3:0]  irdy2;

  int n_checks;
  int n_pass;

  bit         m_v    [3];
  logic [7:0] m_data [3];
  int         m_src  [3];
  int         m_ptr  [3];

  mux_n_pipe #(.WIDTH(8), .NUM_IN(4), .MODE(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy0),
    .in_data(idat[0]), .sel(sel[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .out_src(os[0])
  );

  mux_n_pipe #(.WIDTH(8), .NUM_IN(3), .MODE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1][2:0]), .in_ready(irdy1),
    .in_data(idat[1][23:0]), .sel(sel[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .out_src(os[1])
  );

  mux_n_pipe #(.WIDTH(8), .NUM_IN(4), .MODE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy2),
    .in_data(idat[2]), .sel(sel[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]), .out_src(os[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int d, input string nm,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL dut%0d %s got=%0h exp=%0h t=%0t", d, nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] got_rdy(input int d);
    if (d == 0) return irdy0;
    if (d == 1) return {1'b0, irdy1};
    return irdy2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: decide the winner from the rules, then apply the transfer.
  always @(negedge clk) begin
    int g;
    int c;
    bit gv;
    logic [3:0] er;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_v[d] = 0;
        m_data[d] = 8'h00;
        m_src[d] = 0;
        m_ptr[d] = 0;
      end
      gv = 0;
      g = 0;
      c = 0;
      if (MD[d] == 0) begin
        if (int'(sel[d]) < NI[d] && iv[d][sel[d]]) begin
          gv = 1;
          g = int'(sel[d]);
        end
      end else begin
        for (int k = 0; k < NI[d]; k++) begin
          c = (m_ptr[d] + k) % NI[d];
          if (!gv && iv[d][c]) begin
            gv = 1;
            g = c;
          end
        end
      end
      if (!rst_n || (m_v[d] && !ordy[d])) gv = 0;
      er = gv ? (4'b0001 << g) : 4'b0000;
      chk(d, "in_ready", got_rdy(d), er);
      chk(d, "out_valid", ov[d], m_v[d]);
      chk(d, "out_data", od[d], m_data[d]);
      chk(d, "out_src", os[d], m_src[d]);
      if (rst_n) begin
        if (gv) begin
          m_v[d] = 1;
          m_data[d] = idat[d][8*g +: 8];
          m_src[d] = g;
          m_ptr[d] = (g + 1) % NI[d];
        end else if (ordy[d]) begin
          m_v[d] = 0;
        end
      end
    end
  end

  initial begin
    int seq0 [5];
    int seq1 [3];
    seq0 = '{0, 1, 2, 3, 0};
    seq1 = '{2, 3, 0};
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 4'h0;
      idat[d] = 32'h0;
      sel[d] = 2'd0;
      ordy[d] = 1'b0;
    end
    step();
    step();
    chk(0, "rst_valid", ov[0], 1'b0);
    chk(2, "rst_ready", irdy2, 4'h0);
    rst_n = 1'b1;
    step();

    // Explicit select of channel 2.
    idat[0] = 32'h44434241;
    iv[0] = 4'hF;
    sel[0] = 2'd2;
    ordy[0] = 1'b1;
    #1;
    chk(0, "t1_ready", irdy0, 4'b0100);
    step();
    chk(0, "t1_valid", ov[0], 1'b1);
    chk(0, "t1_data", od[0], 8'h43);
    chk(0, "t1_src", os[0], 2'd2);

    // Backpressure while sel moves to 1.
    ordy[0] = 1'b0;
    sel[0] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(0, "t2_hold_data", od[0], 8'h43);
      chk(0, "t2_hold_ready", irdy0, 4'h0);
    end
    ordy[0] = 1'b1;
    #1;
    chk(0, "t2_rel_ready", irdy0, 4'b0010);
    step();
    chk(0, "t2_data", od[0], 8'h42);
    chk(0, "t2_src", os[0], 2'd1);
    iv[0] = 4'h0;

    // Out-of-range select on the 3-input instance.
    idat[1] = 32'h00434241;
    iv[1] = 4'h7;
    sel[1] = 2'd3;
    ordy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk(1, "t3_ready", {29'd0, irdy1}, 32'd0);
      chk(1, "t3_valid", ov[1], 1'b0);
    end
    iv[1] = 4'h0;

    // Round-robin rotation, then skipping channel 1.
    idat[2] = 32'h44434241;
    iv[2] = 4'hF;
    ordy[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk(2, "t4_src", os[2], seq0[i]);
      chk(2, "t4_data", od[2], 8'h41 + seq0[i]);
    end
    iv[2] = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk(2, "t4_skip_src", os[2], seq1[i]);
    end

    // Stall fairness: load channel 2, stall, next grant is 3.
    iv[2] = 4'b0100;
    step();
    chk(2, "t5_src", os[2], 2'd2);
    iv[2] = 4'hF;
    ordy[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk(2, "t5_hold_src", os[2], 2'd2);
      chk(2, "t5_hold_ready", irdy2, 4'h0);
    end
    ordy[2] = 1'b1;
    #1;
    chk(2, "t5_rel_ready", irdy2, 4'b1000);
    step();
    chk(2, "t5_next_src", os[2], 2'd3);

    // Asynchronous reset with a word held.
    ordy[2] = 1'b0;
    sel[0] = 2'd0;
    iv[0] = 4'hF;
    ordy[0] = 1'b0;
    step();
    chk(0, "t6_pre_data", od[0], 8'h41);
    chk(0, "t6_pre_valid", ov[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk(0, "t6_rst_valid", ov[0], 1'b0);
    chk(0, "t6_rst_data", od[0], 8'h00);
    chk(2, "t6_rst_src", os[2], 2'd0);
    chk(0, "t6_rst_ready", irdy0, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    iv[0] = 4'h0;
    iv[2] = 4'hF;
    ordy[2] = 1'b1;
    step();
    chk(2, "t6_first_src", os[2], 2'd0);
    chk(2, "t6_first_valid", ov[2], 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d] = 4'($urandom);
        sel[d] = 2'($urandom);
        ordy[d] = ($urandom_range(3) != 0);
        idat[d] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
